cayde_decode: RTL and testbench

Registered decode stage sitting directly upstream of the cayde ALU. It accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake and reads the two source registers from the register file. It then presents a registered ALU opcode, operand pair and writeback control to the execute stage. Instruction forms the ALU cannot execute are flagged illegal, not dropped.

---
 rtl/cayde_pkg.sv | 30 +++
 rtl/cayde_imm_gen.sv | 15 +
 rtl/cayde_decode.sv | 155 +++++++++++++++
 tb/tb_cayde_decode.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cayde_pkg.sv
// Shared constants and types for the cayde decode/execute front end.
package cayde_pkg;

  localparam logic [6:0] ALU_ADD = 7'd0;
  localparam logic [6:0] ALU_SUB = 7'd1;
  localparam logic [6:0] ALU_XOR = 7'd2;
  localparam logic [6:0] ALU_AND = 7'd3;
  localparam logic [6:0] ALU_OR  = 7'd4;
  localparam logic [6:0] ALU_SLL = 7'd6;
  localparam logic [6:0] ALU_SRL = 7'd8;
  localparam logic [6:0] ALU_SRA = 7'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/cayde_imm_gen.sv
// I/U immediates and shift amount, taken from the upper instruction bits.
module cayde_imm_gen
  import cayde_pkg::*;
(
  input  logic [31:12] instr_i,
  output logic [31:0]  imm_i_o,
  output logic [31:0]  imm_u_o,
  output logic [31:0]  shamt_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u_o = {instr_i[31:12], 12'b0};
  assign shamt_o = {27'b0, instr_i[24:20]};

endmodule

// File: rtl/cayde_decode.sv
// RV32I decode stage: one instruction per cycle into a registered ALU bundle.
module cayde_decode
  import cayde_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [6:0]      alu_op_o,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic [4:0]      rd_o,
  output logic            we_o,
  output logic            illegal_o,
  output logic [31:0]     decoded_cnt_o
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]  state_q, state_d;
  bundle_t     bundle_q, dec;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] imm_i, imm_u, shamt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        legal, accept, handoff;

  cayde_imm_gen u_imm (
    .instr_i (instr_i[31:12]),
    .imm_i_o (imm_i),
    .imm_u_o (imm_u),
    .shamt_o (shamt)
  );

  assign opc        = instr_i[6:0];
  assign f3         = instr_i[14:12];
  assign f7         = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    dec.rd = instr_i[11:7];
    unique case (opc)
      OPC_OP: begin
        dec.op_a = rs1_data_i;
        dec.op_b = rs2_data_i;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          case (f3)
            3'd0: dec.alu_op = ALU_ADD;
            3'd1: dec.alu_op = ALU_SLL;
            3'd4: dec.alu_op = ALU_XOR;
            3'd5: dec.alu_op = ALU_SRL;
            3'd6: dec.alu_op = ALU_OR;
            3'd7: dec.alu_op = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT) begin
          legal = (f3 == 3'd0) || (f3 == 3'd5);
          dec.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end
        // Register shifts only honour the low five bits of rs2.
        if (f3 == 3'd1 || f3 == 3'd5) dec.op_b = {27'b0, rs2_data_i[4:0]};
      end
      OPC_OPIMM: begin
        dec.op_a = rs1_data_i;
        dec.op_b = imm_i;
        legal    = 1'b1;
        case (f3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd4: dec.alu_op = ALU_XOR;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          3'd1: begin
            dec.alu_op = ALU_SLL;
            dec.op_b   = shamt;
            legal      = (f7 == F7_BASE);
          end
          3'd5: begin
            dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.op_b   = shamt;
            legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op_b = imm_u;
        legal    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op_a = pc_i;
        dec.op_b = imm_u;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal forms still travel downstream, but carry no operation.
    if (!legal) begin
      dec.alu_op = ALU_ADD;
      dec.op_a   = '0;
      dec.op_b   = '0;
    end
    dec.we      = legal && (dec.rd != 5'd0);
    dec.illegal = !legal;
  end

  assign valid_o       = (state_q == S_FULL);
  assign instr_ready_o = !valid_o || ready_i;
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;
  assign handoff       = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = handoff ? cnt_q + 32'd1 : cnt_q;
    if (flush_i)      state_d = S_EMPTY;
    else if (accept)  state_d = S_FULL;
    else if (handoff) state_d = S_EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) bundle_q <= dec;
    end
  end

  assign alu_op_o      = bundle_q.alu_op;
  assign op_a_o        = bundle_q.op_a;
  assign op_b_o        = bundle_q.op_b;
  assign rd_o          = bundle_q.rd;
  assign we_o          = bundle_q.we;
  assign illegal_o     = bundle_q.illegal;
  assign decoded_cnt_o = cnt_q;

endmodule

// File: tb/tb_cayde_decode.sv
// Bench for cayde_decode: directed vector table, handshake corners, random vs. reference model.
module tb_cayde_decode;

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, instr_valid_i, ready_i;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic        instr_ready_o, valid_o, we_o, illegal_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_o;
  logic [6:0]  alu_op_o;
  logic [31:0] op_a_o, op_b_o, decoded_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cayde_decode #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .alu_op_o(alu_op_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .rd_o(rd_o), .we_o(we_o), .illegal_o(illegal_o),
    .decoded_cnt_o(decoded_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input exp_t e);
    chk({name, ".valid"}, 32'(valid_o), 32'd1);
    chk({name, ".op"}, 32'(alu_op_o), 32'(e.op));
    chk({name, ".a"}, op_a_o, e.a);
    chk({name, ".b"}, op_b_o, e.b);
    chk({name, ".rd"}, 32'(rd_o), 32'(e.rd));
    chk({name, ".we"}, 32'(we_o), 32'(e.we));
    chk({name, ".ill"}, 32'(illegal_o), 32'(e.ill));
  endtask

  // Architectural meaning of each instruction, written from the ISA tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    int op = -1;
    e = '0;
    e.rd = ins[11:7];
    if (opc == 7'h33) begin
      e.a = r1;
      e.b = r2;
      if (f7 == 7'h00) begin
        case (f3)
          0: op = 0; 1: op = 6; 4: op = 2; 5: op = 8; 6: op = 4; 7: op = 3;
          default: op = -1;
        endcase
      end else if (f7 == 7'h20) begin
        if (f3 == 0) op = 1;
        if (f3 == 5) op = 9;
      end
      if (op == 6 || op == 8 || op == 9) e.b = r2 % 32;
    end else if (opc == 7'h13) begin
      e.a = r1;
      e.b = 32'($signed(ins[31:20]));
      case (f3)
        0: op = 0; 4: op = 2; 6: op = 4; 7: op = 3;
        1: op = (f7 == 7'h00) ? 6 : -1;
        5: op = (f7 == 7'h00) ? 8 : (f7 == 7'h20) ? 9 : -1;
        default: op = -1;
      endcase
      if (f3 == 1 || f3 == 5) e.b = 32'(ins[24:20]);
    end else if (opc == 7'h37) begin
      op = 0; e.a = 0; e.b = ins & 32'hFFFFF000;
    end else if (opc == 7'h17) begin
      op = 0; e.a = pc; e.b = ins & 32'hFFFFF000;
    end
    if (op < 0) begin
      e.op = 0; e.a = 0; e.b = 0; e.ill = 1'b1; e.we = 1'b0;
    end else begin
      e.op = 7'(op); e.ill = 1'b0; e.we = (e.rd != 0);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr_valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
  endtask

  vec_t vecs[12];
  exp_t e_hold;

  initial begin
    vecs[0]  = '{32'h00500093, 32'h0,   32'h0,        32'h0,        '{7'd0, 32'h0,        32'd5,        5'd1, 1'b1, 1'b0}};
    vecs[1]  = '{32'h402081B3, 32'h0,   32'd10,       32'd3,        '{7'd1, 32'd10,       32'd3,        5'd3, 1'b1, 1'b0}};
    vecs[2]  = '{32'h40335293, 32'h0,   32'h80000000, 32'h0,        '{7'd9, 32'h80000000, 32'd3,        5'd5, 1'b1, 1'b0}};
    vecs[3]  = '{32'h003110B3, 32'h0,   32'd7,        32'h25,       '{7'd6, 32'd7,        32'd5,        5'd1, 1'b1, 1'b0}};
    vecs[4]  = '{32'h123453B7, 32'h0,   32'hDEAD,     32'h0,        '{7'd0, 32'h0,        32'h12345000, 5'd7, 1'b1, 1'b0}};
    vecs[5]  = '{32'h00001117, 32'h100, 32'h55,       32'h0,        '{7'd0, 32'h100,      32'h1000,     5'd2, 1'b1, 1'b0}};
    vecs[6]  = '{32'h003120B3, 32'h0,   32'd4,        32'd9,        '{7'd0, 32'h0,        32'h0,        5'd1, 1'b0, 1'b1}};
    vecs[7]  = '{32'h00100013, 32'h0,   32'h0,        32'h0,        '{7'd0, 32'h0,        32'd1,        5'd0, 1'b0, 1'b0}};
    vecs[8]  = '{32'hFFF20213, 32'h0,   32'h10,       32'h0,        '{7'd0, 32'h10,       32'hFFFFFFFF, 5'd4, 1'b1, 1'b0}};
    vecs[9]  = '{32'h40109093, 32'h0,   32'h3,        32'h0,        '{7'd0, 32'h0,        32'h0,        5'd1, 1'b0, 1'b1}};
    vecs[10] = '{32'h003150B3, 32'h0,   32'hF0,       32'hFFFFFFE4, '{7'd8, 32'hF0,       32'd4,        5'd1, 1'b1, 1'b0}};
    vecs[11] = '{32'h003170B3, 32'h0,   32'hF0,       32'h3C,       '{7'd3, 32'hF0,       32'h3C,       5'd1, 1'b1, 1'b0}};

    do_reset();
    chk("rst.valid", 32'(valid_o), 0);
    chk("rst.op", 32'(alu_op_o), 0);
    chk("rst.a", op_a_o, 0);
    chk("rst.b", op_b_o, 0);
    chk("rst.rd", 32'(rd_o), 0);
    chk("rst.we", 32'(we_o), 0);
    chk("rst.ill", 32'(illegal_o), 0);
    chk("rst.cnt", decoded_cnt_o, 0);
    chk("rst.rdy", 32'(instr_ready_o), 1);

    // Directed table, back-to-back with ready_i high.
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      #1;
      chk($sformatf("vec%0d.rs", i), {22'b0, rs1_addr_o, rs2_addr_o},
          {22'b0, vecs[i].instr[19:15], vecs[i].instr[24:20]});
      tick();
      chk_bundle($sformatf("vec%0d", i), vecs[i].e);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("vec.cnt", decoded_cnt_o, 32'd12);
    chk("vec.drain", 32'(valid_o), 0);

    // Backpressure: second instruction waits while the first is stalled.
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
    tick();
    e_hold = '{7'd0, 32'h0, 32'd5, 5'd1, 1'b1, 1'b0};
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d.rdy", c), 32'(instr_ready_o), 0);
      tick();
      chk_bundle($sformatf("bp%0d", c), e_hold);
    end
    ready_i = 1'b1;
    tick();
    chk_bundle("bp.second", '{7'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0});
    chk("bp.cnt1", decoded_cnt_o, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp.cnt2", decoded_cnt_o, 32'd2);
    chk("bp.empty", 32'(valid_o), 0);

    // Flush while full, with an instruction offered in the same cycle.
    do_reset();
    drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 32'h123453B7, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl.valid", 32'(valid_o), 0);
    chk("fl.cnt", decoded_cnt_o, 32'd0);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl.noaccept", 32'(valid_o), 0);
    drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
    tick();
    flush_i = 1'b1; ready_i = 1'b1;
    tick();
    chk("fl2.valid", 32'(valid_o), 0);
    chk("fl2.cnt", decoded_cnt_o, 32'd1);
    flush_i = 1'b0;

    // Reset while stalled drops the bundle.
    ready_i = 1'b0;
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3);
    tick();
    chk("rs.loaded", 32'(valid_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rs.valid", 32'(valid_o), 0);
    chk("rs.zero", {alu_op_o, rd_o, we_o, illegal_o} | op_a_o | op_b_o | decoded_cnt_o, 32'h0);

    // Random traffic against a transaction-level model.
    begin
      logic m_valid = 1'b0;
      logic [31:0] m_cnt = 32'h0;
      exp_t m_b = '0;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        logic [6:0] opc, f7;
        logic [31:0] ins;
        logic handoff, accept;
        case ($urandom_range(0, 5))
          0, 1: opc = 7'h33;
          2, 3: opc = 7'h13;
          4:    opc = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
          default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0, 1: f7 = 7'h00;
          2:    f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        ins = {f7, 25'($urandom)};
        ins[6:0] = opc;
        drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom);
        ready_i = ($urandom_range(0, 3) != 0);
        flush_i = ($urandom_range(0, 15) == 0);
        #1;
        chk("rnd.rdy", 32'(instr_ready_o), 32'(!m_valid || ready_i));
        handoff = m_valid && ready_i;
        accept  = instr_valid_i && (!m_valid || ready_i) && !flush_i;
        if (handoff) m_cnt++;
        if (flush_i) m_valid = 1'b0;
        else if (accept) begin
          m_valid = 1'b1;
          m_b = ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
        end else if (handoff) m_valid = 1'b0;
        tick();
        chk("rnd.valid", 32'(valid_o), 32'(m_valid));
        if (m_valid) chk_bundle("rnd", m_b);
        chk("rnd.cnt", decoded_cnt_o, m_cnt);
      end
      flush_i = 1'b0;
    end

    // Counter wrap from a preset value.
    do_reset();
    force dut.cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.cnt_q;
    ready_i = 1'b1;
    drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("wrap.ff", decoded_cnt_o, 32'hFFFFFFFF);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("wrap.zero", decoded_cnt_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
